// File: rtl/dense_neuron_seq_if.sv
// Start/ready/done handshake, configuration port and result bus of dense_neuron_seq.
// The neuron is the slave; the layer controller (or a bench) is the master.
interface dense_neuron_seq_if #(
   parameter int N_IN = 2
);
   localparam int AW = $clog2(N_IN + 1);

   logic                   ap_start;
   logic                   ap_ready;
   logic                   ap_done;
   logic                   ap_idle;
   logic [16*N_IN-1:0]     input_V;
   logic                   input_V_ap_vld;
   logic                   cfg_we;
   logic [AW-1:0]          cfg_addr;
   logic signed [15:0]     cfg_data;
   logic signed [15:0]     out_V;
   logic                   out_V_ap_vld;

   modport master (
      output ap_start, input_V, input_V_ap_vld, cfg_we, cfg_addr, cfg_data,
      input  ap_ready, ap_done, ap_idle, out_V, out_V_ap_vld
   );

   modport slave (
      input  ap_start, input_V, input_V_ap_vld, cfg_we, cfg_addr, cfg_data,
      output ap_ready, ap_done, ap_idle, out_V, out_V_ap_vld
   );
endinterface

// File: rtl/dense_neuron_seq.sv
// Single dense neuron: one shared 16x16 multiplier walks the latched input vector,
// then the floored, biased sum is saturated to 16 bits and pulsed out.
module dense_neuron_seq #(
   parameter int N_IN = 2,
   parameter int FRAC = 10
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   dense_neuron_seq_if.slave bus
);
   localparam int AW    = $clog2(N_IN + 1);
   localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int ACC_W = 32 + $clog2(N_IN) + 1;

   typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} state_t;

   state_t                  state_reg, state_next;
   logic [IW-1:0]           idx_reg;
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [15:0]      bias_reg;
   logic signed [15:0]      out_reg;

   logic [16*N_IN-1:0]      x_flat;
   logic [16*N_IN-1:0]      w_flat;
   logic                    accept;
   logic                    cfg_ok;
   logic                    last_mac;
   logic signed [15:0]      x_sel;
   logic signed [15:0]      w_sel;
   logic signed [31:0]      product;
   logic signed [ACC_W-1:0] shifted;
   logic [ACC_W:0]          biased;
   logic signed [15:0]      sat;

   assign cfg_ok = bus.cfg_we && (state_reg == IDLE);

   // Per-lane storage: latched activation and its weight.
   for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
      logic [15:0] x_q;
      logic [15:0] w_q;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
         if (!ap_rst_n) begin
            x_q <= '0;
            w_q <= '0;
         end else begin
            if (accept) begin
               x_q <= bus.input_V[16*gi +: 16];
            end
            if (cfg_ok && (bus.cfg_addr == AW'(gi))) begin
               w_q <= bus.cfg_data;
            end
         end
      end

      assign x_flat[16*gi +: 16] = x_q;
      assign w_flat[16*gi +: 16] = w_q;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      last_mac   = (idx_reg == IW'(N_IN - 1));
      case (state_reg)
         IDLE: begin
            if (bus.ap_start && bus.input_V_ap_vld) begin
               accept     = 1'b1;
               state_next = MAC;
            end
         end
         MAC: begin
            if (last_mac) begin
               state_next = BIAS;
            end
         end
         BIAS:    state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      x_sel = '0;
      w_sel = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (idx_reg == IW'(i)) begin
            x_sel = x_flat[16*i +: 16];
            w_sel = w_flat[16*i +: 16];
         end
      end
   end

   assign product = x_sel * w_sel;

   // Arithmetic shift floors toward -inf; the sum fits in 16 bits only when
   // every bit from 15 upward matches the sign.
   always_comb begin
      shifted = acc_reg >>> FRAC;
      biased  = {shifted[ACC_W-1], shifted} + {{(ACC_W + 1 - 16){bias_reg[15]}}, bias_reg};
      if ((&biased[ACC_W:15]) || !(|biased[ACC_W:15])) begin
         sat = biased[15:0];
      end else if (biased[ACC_W]) begin
         sat = 16'sh8000;
      end else begin
         sat = 16'sh7fff;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         idx_reg  <= '0;
         acc_reg  <= '0;
         bias_reg <= '0;
         out_reg  <= '0;
      end else begin
         if (cfg_ok && (bus.cfg_addr == AW'(N_IN))) begin
            bias_reg <= bus.cfg_data;
         end
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  acc_reg <= '0;
                  idx_reg <= '0;
               end
            end
            MAC: begin
               acc_reg <= acc_reg + ACC_W'(product);
               idx_reg <= idx_reg + 1'b1;
            end
            BIAS:    out_reg <= sat;
            default: ;
         endcase
      end
   end

   assign bus.ap_ready     = accept;
   assign bus.ap_idle      = (state_reg == IDLE);
   assign bus.ap_done      = (state_reg == OUT);
   assign bus.out_V_ap_vld = (state_reg == OUT);
   assign bus.out_V        = out_reg;
endmodule

// File: tb/tb_dense_neuron_seq.sv
// Directed bench for dense_neuron_seq (N_IN=2, FRAC=10) with hand-computed expectations.
module tb_dense_neuron_seq;
   localparam int N_IN = 2;

   logic ap_clk;
   logic ap_rst_n;
   int   total;
   int   bad;
   int   rcnt;
   int   dcnt;
   int   done_seen;
   logic [31:0]        b2b_in   [3];
   logic signed [15:0] b2b_want [3];

   dense_neuron_seq_if #(.N_IN(N_IN)) bus ();

   dense_neuron_seq #(.N_IN(N_IN), .FRAC(10)) dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .bus      (bus)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(want));
      end
   endtask

   task automatic checkb(input string tag, input logic obs, input logic want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, want);
      end
   endtask

   // Called and returns at 1 time unit after a rising edge.
   task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr;
      bus.cfg_data = data;
      @(posedge ap_clk); #1;
      bus.cfg_we   = 1'b0;
   endtask

   task automatic run(input string tag, input logic [15:0] x0, input logic [15:0] x1,
                      input logic signed [15:0] want);
      bus.input_V        = {x1, x0};
      bus.ap_start       = 1'b1;
      bus.input_V_ap_vld = 1'b1;
      @(negedge ap_clk);
      checkb({tag, "_ready"}, bus.ap_ready, 1'b1);
      @(posedge ap_clk); #1;
      bus.ap_start       = 1'b0;
      bus.input_V_ap_vld = 1'b0;
      bus.input_V        = '1;
      for (int c = 1; c <= N_IN + 2; c++) begin
         @(negedge ap_clk);
         checkb({tag, "_done"}, bus.ap_done, (c == N_IN + 2));
         if (c == N_IN + 2) begin
            checkb({tag, "_vld"}, bus.out_V_ap_vld, 1'b1);
            check({tag, "_out"}, bus.out_V, want);
            $display("txn %s out_V=%0d want=%0d", tag, bus.out_V, want);
         end
         @(posedge ap_clk); #1;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      b2b_in[0] = {16'd2048, 16'd1024};
      b2b_in[1] = 32'd0;
      b2b_in[2] = {16'd1024, 16'd2048};
      b2b_want[0] = 16'sd477;
      b2b_want[1] = 16'sd157;
      b2b_want[2] = -16'sd115;
      ap_rst_n           = 1'b0;
      bus.ap_start       = 1'b0;
      bus.input_V_ap_vld = 1'b0;
      bus.input_V        = '0;
      bus.cfg_we         = 1'b0;
      bus.cfg_addr       = '0;
      bus.cfg_data       = '0;

      repeat (2) @(posedge ap_clk);
      #1;
      checkb("rst_idle", bus.ap_idle, 1'b1);
      checkb("rst_ready", bus.ap_ready, 1'b0);
      checkb("rst_done", bus.ap_done, 1'b0);
      checkb("rst_vld", bus.out_V_ap_vld, 1'b0);
      check("rst_out", bus.out_V, 32'd0);
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      // Start without valid input stays idle.
      bus.ap_start = 1'b1;
      @(negedge ap_clk);
      checkb("novld_ready", bus.ap_ready, 1'b0);
      @(posedge ap_clk); #1;
      bus.ap_start = 1'b0;
      @(negedge ap_clk);
      checkb("novld_idle", bus.ap_idle, 1'b1);
      @(posedge ap_clk); #1;

      // Nominal: (1024*-288 + 2048*304) >>> 10 + 157 = 477.
      cfg_write(2'd0, 16'hFEE0);
      cfg_write(2'd1, 16'd304);
      cfg_write(2'd2, 16'd157);
      run("nominal", 16'd1024, 16'd2048, 16'sd477);

      // Busy: start and a w0 write during MAC must both be ignored.
      bus.input_V        = {16'd2048, 16'd1024};
      bus.ap_start       = 1'b1;
      bus.input_V_ap_vld = 1'b1;
      @(negedge ap_clk);
      checkb("busy_acc_ready", bus.ap_ready, 1'b1);
      @(posedge ap_clk); #1;
      bus.input_V = {16'd0, 16'd0};
      @(negedge ap_clk);
      checkb("busy_start_ready", bus.ap_ready, 1'b0);
      checkb("busy_idle", bus.ap_idle, 1'b0);
      @(posedge ap_clk); #1;
      bus.ap_start       = 1'b0;
      bus.input_V_ap_vld = 1'b0;
      bus.cfg_we         = 1'b1;
      bus.cfg_addr       = 2'd0;
      bus.cfg_data       = 16'd5;
      @(negedge ap_clk);
      checkb("busy_mac_done", bus.ap_done, 1'b0);
      @(posedge ap_clk); #1;
      bus.cfg_we = 1'b0;
      @(negedge ap_clk);
      checkb("busy_bias_done", bus.ap_done, 1'b0);
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      checkb("busy_out_done", bus.ap_done, 1'b1);
      check("busy_out", bus.out_V, 32'd477);
      $display("txn busy out_V=%0d want=477", bus.out_V);
      @(posedge ap_clk); #1;
      run("busy_oldw", 16'd1024, 16'd2048, 16'sd477);

      // Back-to-back: accepts every 5 cycles, done 4 cycles after each.
      rcnt = 0;
      dcnt = 0;
      bus.input_V        = b2b_in[0];
      bus.ap_start       = 1'b1;
      bus.input_V_ap_vld = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge ap_clk);
         if (bus.ap_ready) begin
            check("b2b_ready_cycle", c, 5 * rcnt);
            rcnt++;
         end
         if (bus.ap_done) begin
            check("b2b_done_cycle", c, 5 * dcnt + 4);
            if (dcnt < 3) begin
               check("b2b_out", bus.out_V, b2b_want[dcnt]);
               $display("txn b2b%0d out_V=%0d want=%0d", dcnt, bus.out_V, b2b_want[dcnt]);
            end
            dcnt++;
         end
         @(posedge ap_clk); #1;
         if (rcnt > 0 && rcnt < 3) bus.input_V = b2b_in[rcnt];
      end
      bus.ap_start       = 1'b0;
      bus.input_V_ap_vld = 1'b0;
      check("b2b_ready_count", rcnt, 3);
      check("b2b_done_count", dcnt, 3);

      // Saturation both ways.
      cfg_write(2'd0, 16'h7FFF);
      cfg_write(2'd1, 16'h7FFF);
      cfg_write(2'd2, 16'h0000);
      run("sat_pos", 16'h7FFF, 16'h7FFF, 16'sh7FFF);
      run("sat_neg", 16'h8000, 16'h8000, -16'sd32768);

      // Floor: -1 >>> 10 = -1.
      cfg_write(2'd0, 16'hFFFF);
      cfg_write(2'd1, 16'h0000);
      run("floor", 16'd1, 16'd0, -16'sd1);

      // Address above the bias slot is dropped.
      cfg_write(2'd3, 16'd100);
      run("addr_oob", 16'd1, 16'd0, -16'sd1);

      // Reset during MAC discards the inference and clears weights.
      cfg_write(2'd0, 16'hFEE0);
      cfg_write(2'd1, 16'd304);
      cfg_write(2'd2, 16'd157);
      bus.input_V        = {16'd2048, 16'd1024};
      bus.ap_start       = 1'b1;
      bus.input_V_ap_vld = 1'b1;
      @(negedge ap_clk);
      checkb("rstmid_ready", bus.ap_ready, 1'b1);
      @(posedge ap_clk); #1;
      bus.ap_start       = 1'b0;
      bus.input_V_ap_vld = 1'b0;
      ap_rst_n = 1'b0;
      #1;
      checkb("rstmid_idle", bus.ap_idle, 1'b1);
      checkb("rstmid_done", bus.ap_done, 1'b0);
      check("rstmid_out", bus.out_V, 32'd0);
      @(posedge ap_clk); #1;
      ap_rst_n  = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge ap_clk);
         if (bus.ap_done) done_seen++;
         @(posedge ap_clk); #1;
      end
      check("rstmid_no_done", done_seen, 0);
      run("rst_zero_w", 16'd1024, 16'd2048, 16'sd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
